// File: rtl/garage_occupancy_display.sv
// rtl/garage_occupancy_display.sv - garage occupancy counter with BCD digit chain and 7-segment drive
//
// Purpose:
//   Counts cars from entry/exit sensor levels, saturating at 0 and CAPACITY.
//   A registered BCD digit chain is incremented/decremented alongside the
//   binary count, so no divide/modulo logic is needed for the display.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   clear    in   synchronous clear of occupancy (wins over sensor events)
//   car_in   in   entry sensor level
//   car_out  in   exit sensor level
//   count    out  binary occupancy [CNT_W-1:0]
//   bcd      out  BCD digits, units in [3:0]
//   leds     out  segments abcdefg per digit, digit k in [7k+6:7k], active-high
//   full     out  count == CAPACITY
//   empty    out  count == 0
//   reject   out  one-cycle pulse on a refused entry or exit
//
// Build option:
//   GARAGE_BLANK_LEADING_ZERO_EN - blank leading zero digits (units never blanked)

module garage_occupancy_display #(
  parameter int CAPACITY = 40,
  parameter int DIGITS   = 2,
  parameter int CNT_W    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  car_in,
  input  logic                  car_out,
  output logic [CNT_W-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   leds,
  output logic                  full,
  output logic                  empty,
  output logic                  reject
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  // Elaboration-time parameter sanity checks
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("DIGITS must be in 1..4");
  end
  if (CAPACITY > (10 ** DIGITS) - 1) begin : g_bad_cap_dec
    $error("CAPACITY does not fit in DIGITS decimal digits");
  end
  if (CAPACITY >= (2 ** CNT_W)) begin : g_bad_cap_bin
    $error("CAPACITY does not fit in CNT_W bits");
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [CNT_W-1:0]    count_q, count_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                in_q, out_q;
  logic                reject_q, reject_d;

  logic                ev_in, ev_out;

  assign ev_in  = car_in  & ~in_q;
  assign ev_out = car_out & ~out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      bcd_q    <= '0;
      in_q     <= 1'b0;
      out_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      bcd_q    <= bcd_d;
      in_q     <= car_in;
      out_q    <= car_out;
      reject_q <= reject_d;
    end
  end

  // ------------------------------------------------------------------
  // BCD chain +1 / -1; carry and borrow ripple through all digits in
  // one cycle. Saturation is handled by the caller, so the top digit
  // never actually wraps.
  // ------------------------------------------------------------------
  logic [4*DIGITS-1:0] bcd_inc, bcd_dec;
  logic                carry, borrow;

  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (bcd_q[4*k +: 4] == 4'd9) begin
          bcd_inc[4*k +: 4] = 4'd0;
        end else begin
          bcd_inc[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bcd_dec = bcd_q;
    borrow  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (bcd_q[4*k +: 4] == 4'd0) begin
          bcd_dec[4*k +: 4] = 4'd9;
        end else begin
          bcd_dec[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state: clear > simultaneous events > entry > exit > hold
  // ------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    bcd_d    = bcd_q;
    reject_d = 1'b0;
    if (clear) begin
      count_d = '0;
      bcd_d   = '0;
    end else if (ev_in && ev_out) begin
      // a car entering while another leaves: net zero
    end else if (ev_in) begin
      if (count_q < CAP_C) begin
        count_d = count_q + CNT_W'(1);
        bcd_d   = bcd_inc;
      end else begin
        reject_d = 1'b1;
      end
    end else if (ev_out) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
        bcd_d   = bcd_dec;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Display
  // ------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

`ifdef GARAGE_BLANK_LEADING_ZERO_EN
  // Walk from the most significant digit down; a zero digit is blanked
  // while every digit above it is also zero. Units always shows.
  logic zero_above;

  always_comb begin
    leds       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (k != 0 && zero_above && bcd_q[4*k +: 4] == 4'd0) begin
        leds[7*k +: 7] = 7'b0000000;
      end else begin
        leds[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
      end
      zero_above = zero_above && (bcd_q[4*k +: 4] == 4'd0);
    end
  end
`else
  always_comb begin
    leds = '0;
    for (int k = 0; k < DIGITS; k++) begin
      leds[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end
`endif

  assign count  = count_q;
  assign bcd    = bcd_q;
  assign full   = (count_q == CAP_C);
  assign empty  = (count_q == '0);
  assign reject = reject_q;

  // ------------------------------------------------------------------
  // The BCD chain must always mirror the binary count
  // ------------------------------------------------------------------
  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v;
    v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v = v * 10 + int'(b[4*k +: 4]);
    end
    return v;
  endfunction

  a_bcd_matches_count: assert property (
    @(posedge clk) disable iff (!reset) bcd_value(bcd_q) == int'(count_q)
  );

endmodule

// File: tb/tb_garage_occupancy_display.sv
// tb/tb_garage_occupancy_display.sv - self-checking bench for garage_occupancy_display

module tb_garage_occupancy_display;

  localparam int CAP = 40;
  localparam int D   = 2;
  localparam int W   = 6;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             car_in;
  logic             car_out;
  logic [W-1:0]     count;
  logic [4*D-1:0]   bcd;
  logic [7*D-1:0]   leds;
  logic             full;
  logic             empty;
  logic             reject;

  garage_occupancy_display #(
    .CAPACITY (CAP),
    .DIGITS   (D),
    .CNT_W    (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .car_in  (car_in),
    .car_out (car_out),
    .count   (count),
    .bcd     (bcd),
    .leds    (leds),
    .full    (full),
    .empty   (empty),
    .reject  (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: occupancy as a plain integer
  int occ;
  bit pin, pout;
  bit exp_rej;

  logic [6:0] seg_tab [10];

  typedef struct packed {
    logic       cin;
    logic       cout;
    logic       clr;
    logic [7:0] exp_cnt;
    logic       exp_rej;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_bcd(input int v);
    int r;
    r = 0;
    for (int d = 0; d < D; d++) r += ((v / (10 ** d)) % 10) << (4 * d);
    return r;
  endfunction

  function automatic int exp_leds(input int v);
    int r;
    int dig;
    logic [6:0] s;
    r = 0;
    for (int d = 0; d < D; d++) begin
      dig = (v / (10 ** d)) % 10;
      s   = seg_tab[dig];
`ifdef GARAGE_BLANK_LEADING_ZERO_EN
      if (d >= 1 && v < 10 ** d) s = 7'b0000000;
`endif
      r |= int'(s) << (7 * d);
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"},  int'(count),  occ);
    chk({tag, ".bcd"},    int'(bcd),    exp_bcd(occ));
    chk({tag, ".leds"},   int'(leds),   exp_leds(occ));
    chk({tag, ".full"},   int'(full),   int'(occ == CAP));
    chk({tag, ".empty"},  int'(empty),  int'(occ == 0));
    chk({tag, ".reject"}, int'(reject), int'(exp_rej));
  endtask

  // One clock: drive after the falling edge, advance the model on the
  // rising edge, then compare 1 ns later.
  task automatic step(input bit ci, input bit co, input bit cl);
    bit evi, evo;
    @(negedge clk);
    car_in  = ci;
    car_out = co;
    clear   = cl;
    @(posedge clk);
    evi  = ci && !pin;
    evo  = co && !pout;
    pin  = ci;
    pout = co;
    exp_rej = 1'b0;
    if (cl)              occ = 0;
    else if (evi && evo) ;
    else if (evi) begin
      if (occ < CAP) occ++;
      else           exp_rej = 1'b1;
    end else if (evo) begin
      if (occ > 0) occ--;
      else         exp_rej = 1'b1;
    end
    #1;
    check_all("step");
  endtask

  task automatic pulse_in(input int hold);
    repeat (hold) step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic fill(input int n);
    do_clear();
    repeat (n) pulse_in(1);
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1};

    occ = 0; pin = 0; pout = 0; exp_rej = 0;
    reset = 1'b0; clear = 1'b0; car_in = 1'b0; car_out = 1'b0;

    // Reset state
    #12;
    check_all("reset");
    chk("reset.leds0", int'(leds[6:0]), 7'b1111110);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      step(vecs[i].cin, vecs[i].cout, vecs[i].clr);
      chk($sformatf("vec%0d.count", i),  int'(count),  int'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.reject", i), int'(reject), int'(vecs[i].exp_rej));
    end

    // 12 pulses held 3 cycles each
    do_clear();
    repeat (12) pulse_in(3);
    chk("twelve.count", int'(count), 12);
    chk("twelve.bcd",   int'(bcd),   'h12);
    chk("twelve.dig1",  int'(leds[13:7]), 7'b0110000);
    chk("twelve.dig0",  int'(leds[6:0]),  7'b1101101);

    // 9 -> 10 carry, then 10 -> 9 borrow
    fill(9);
    chk("nine.bcd", int'(bcd), 'h09);
    step(1, 0, 0);
    chk("carry.bcd", int'(bcd), 'h10);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("borrow.bcd",   int'(bcd),   'h09);
    chk("borrow.count", int'(count), 9);
    step(0, 0, 0);

    // Capacity saturation
    fill(CAP);
    chk("cap.full", int'(full), 1);
    step(1, 0, 0);
    chk("cap.count",   int'(count),  CAP);
    chk("cap.reject",  int'(reject), 1);
    step(0, 0, 0);
    chk("cap.reject_one_cycle", int'(reject), 0);

    // Simultaneous entry and exit at 5
    fill(5);
    step(1, 1, 0);
    chk("simul.count",  int'(count),  5);
    chk("simul.reject", int'(reject), 0);
    step(0, 0, 0);

    // Clear at 23 with an entry edge
    fill(23);
    step(1, 0, 1);
    chk("clear23.count", int'(count), 0);
    step(0, 0, 0);

    // Asynchronous reset at 7
    fill(7);
    #2;
    reset = 1'b0;
    #1;
    occ = 0; pin = 0; pout = 0; exp_rej = 0;
    check_all("async_rst");
    chk("async_rst.count", int'(count), 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0);

    // Leading-digit display at 3
    repeat (3) pulse_in(1);
`ifdef GARAGE_BLANK_LEADING_ZERO_EN
    chk("three.dig1", int'(leds[13:7]), 7'b0000000);
`else
    chk("three.dig1", int'(leds[13:7]), 7'b1111110);
`endif
    chk("three.dig0", int'(leds[6:0]), 7'b1111001);

    // Random: entry-heavy, then exit-heavy, to reach both saturation limits
    for (int i = 0; i < 1200; i++)
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 255) == 0));
    for (int i = 0; i < 1200; i++)
      step(($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 255) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
